// File: rtl/stage.sv
// ----------------------------------------------------------------------------
// stage -- one trigger stage of a SUMP-compatible logic analyzer trigger unit.
//
// Holds a mask, a compare value and a configuration word, all loaded from the
// command interface. Once armed, each strobed 32-bit sample is compared under
// the mask. In serial mode the compare word is instead built from a single
// channel shifted through a 32-bit shift register. A qualified hit, optionally
// followed by a strobe-counted delay, fires the stage. Firing produces a
// one-cycle match pulse and, for the start stage, a one-cycle run pulse.
//
// Ports
//   clk_i       clock, rising edge
//   rst_in      synchronous active-high reset
//   cmd_i       command data word for the set_* loads
//   set_mask_i  load mask from cmd_i
//   set_val_i   load compare value from cmd_i
//   set_cfg_i   load configuration from cmd_i:
//               delay [15:0], level [17:16], channel [24:20],
//               serial [26], start [27]
//   arm_i       arm, or restart, the stage
//   stb_i       smpls_i holds a valid sample this cycle
//   smpls_i     sample word
//   lvl_i       current trigger level owned by the controller
//   match_o     registered one-cycle stage-fired pulse
//   run_o       registered one-cycle start-capture pulse
// ----------------------------------------------------------------------------
module stage (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic [31:0] cmd_i,
    input  logic        set_mask_i,
    input  logic        set_val_i,
    input  logic        set_cfg_i,
    input  logic        arm_i,
    input  logic        stb_i,
    input  logic [31:0] smpls_i,
    input  logic [1:0]  lvl_i,
    output logic        match_o,
    output logic        run_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] val_q, val_d;
    logic [15:0] delay_q, delay_d;
    logic [1:0]  level_q, level_d;
    logic [4:0]  chan_q, chan_d;
    logic        serial_q, serial_d;
    logic        start_q, start_d;
    logic [31:0] shreg_q, shreg_d;
    logic [15:0] cnt_q, cnt_d;
    logic        match_q, match_d;
    logic        run_q, run_d;

    logic [31:0] word;
    logic        hit;
    logic        fire;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        val_d    = val_q;
        delay_d  = delay_q;
        level_d  = level_q;
        chan_d   = chan_q;
        serial_d = serial_q;
        start_d  = start_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        fire     = 1'b0;

        // The compare always uses the registers as they stood before this
        // edge, so a load in the same cycle as a strobe takes effect later.
        word = serial_q ? {shreg_q[30:0], smpls_i[chan_q]} : smpls_i;
        hit  = ((word ^ val_q) & mask_q) == 32'd0;

        // The shift register tracks the selected channel on every strobe,
        // whether or not the stage is armed, so history is ready at arm time.
        if (stb_i && serial_q) begin
            shreg_d = word;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    state_d = ST_ARMED;
                    cnt_d   = 16'd0;
                end
            end
            ST_ARMED: begin
                // A re-arm wins over a hit in the same cycle.
                if (arm_i) begin
                    state_d = ST_ARMED;
                    cnt_d   = 16'd0;
                end else if (stb_i && hit && (lvl_i >= level_q)) begin
                    if (delay_q == 16'd0) begin
                        fire = 1'b1;
                    end else begin
                        cnt_d   = delay_q;
                        state_d = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                // Only strobes count down; the level is not rechecked here.
                if (arm_i) begin
                    state_d = ST_ARMED;
                    cnt_d   = 16'd0;
                end else if (stb_i) begin
                    if (cnt_q == 16'd1) begin
                        fire = 1'b1;
                    end
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fire) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
        end
        match_d = fire;
        run_d   = fire & start_q;

        if (set_mask_i) begin
            mask_d = cmd_i;
        end
        if (set_val_i) begin
            val_d = cmd_i;
        end
        if (set_cfg_i) begin
            delay_d  = cmd_i[15:0];
            level_d  = cmd_i[17:16];
            chan_d   = cmd_i[24:20];
            serial_d = cmd_i[26];
            start_d  = cmd_i[27];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            mask_q   <= 32'd0;
            val_q    <= 32'd0;
            delay_q  <= 16'd0;
            level_q  <= 2'd0;
            chan_q   <= 5'd0;
            serial_q <= 1'b0;
            start_q  <= 1'b0;
            shreg_q  <= 32'd0;
            cnt_q    <= 16'd0;
            match_q  <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            val_q    <= val_d;
            delay_q  <= delay_d;
            level_q  <= level_d;
            chan_q   <= chan_d;
            serial_q <= serial_d;
            start_q  <= start_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            run_q    <= run_d;
        end
    end

    assign match_o = match_q;
    assign run_o   = run_q;

endmodule

// File: tb/tb_stage.sv
module tb_stage;

    logic        clk_i = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] cmd_i = 32'd0;
    logic        set_mask_i = 1'b0;
    logic        set_val_i = 1'b0;
    logic        set_cfg_i = 1'b0;
    logic        arm_i = 1'b0;
    logic        stb_i = 1'b0;
    logic [31:0] smpls_i = 32'd0;
    logic [1:0]  lvl_i = 2'd0;
    logic        match_o;
    logic        run_o;

    stage dut (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .cmd_i     (cmd_i),
        .set_mask_i(set_mask_i),
        .set_val_i (set_val_i),
        .set_cfg_i (set_cfg_i),
        .arm_i     (arm_i),
        .stb_i     (stb_i),
        .smpls_i   (smpls_i),
        .lvl_i     (lvl_i),
        .match_o   (match_o),
        .run_o     (run_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    endtask

    // Reference model: what the stage remembers, expressed as "is it armed"
    // and "how many more strobes until it fires".
    logic [31:0] m_mask, m_val, m_sh;
    int          m_delay, m_level, m_chan;
    bit          m_serial, m_start, m_armed;
    int          m_wait;
    bit          exp_match = 1'b0, exp_run = 1'b0;

    always @(posedge clk_i) begin
        logic [31:0] w;
        bit          fire;
        if (rst_in) begin
            m_mask = 0; m_val = 0; m_sh = 0;
            m_delay = 0; m_level = 0; m_chan = 0;
            m_serial = 0; m_start = 0; m_armed = 0; m_wait = 0;
            exp_match = 0; exp_run = 0;
        end else begin
            fire = 0;
            if (m_serial) w = (m_sh << 1) | 32'(smpls_i[m_chan]);
            else          w = smpls_i;
            if (arm_i) begin
                m_armed = 1; m_wait = 0;
            end else if (m_armed && m_wait > 0) begin
                if (stb_i) begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) fire = 1;
                end
            end else if (m_armed && stb_i && ((w & m_mask) == (m_val & m_mask))
                         && int'(lvl_i) >= m_level) begin
                if (m_delay == 0) fire = 1;
                else m_wait = m_delay;
            end
            if (fire) m_armed = 0;
            exp_match = fire;
            exp_run   = fire && m_start;
            if (stb_i && m_serial) m_sh = w;
            if (set_mask_i) m_mask = cmd_i;
            if (set_val_i)  m_val  = cmd_i;
            if (set_cfg_i) begin
                m_delay  = int'(cmd_i[15:0]);
                m_level  = int'(cmd_i[17:16]);
                m_chan   = int'(cmd_i[24:20]);
                m_serial = cmd_i[26];
                m_start  = cmd_i[27];
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("model_match", match_o, exp_match);
            check("model_run", run_o, exp_run);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int which, input logic [31:0] d);
        cmd_i = d;
        set_mask_i = (which == 0);
        set_val_i  = (which == 1);
        set_cfg_i  = (which == 2);
        tick();
        set_mask_i = 0; set_val_i = 0; set_cfg_i = 0;
    endtask

    task automatic do_arm();
        arm_i = 1; tick(); arm_i = 0;
    endtask

    task automatic strobe(input logic [31:0] s);
        stb_i = 1; smpls_i = s; tick(); stb_i = 0;
    endtask

    task automatic expect_out(input string name, input logic m, input logic r);
        check({name, "_match"}, match_o, m);
        check({name, "_run"}, run_o, r);
    endtask

    initial begin
        logic [31:0] s;
        // Reset
        rst_in = 1; tick(); tick(); rst_in = 0;
        chk_en = 1;
        expect_out("reset", 1'b0, 1'b0);

        // Exact match, start stage, no delay
        load(0, 32'hFFFF_FFFF);
        load(1, 32'h0000_00A5);
        load(2, 32'h0800_0000);
        lvl_i = 0;
        do_arm();
        strobe(32'h0000_00A4); expect_out("near_miss", 1'b0, 1'b0);
        strobe(32'h0000_00A5); expect_out("exact_hit", 1'b1, 1'b1);
        tick();                expect_out("pulse_end", 1'b0, 1'b0);
        strobe(32'h0000_00A5); expect_out("no_rearm", 1'b0, 1'b0);

        // Partial mask, not start stage
        load(0, 32'h0000_000F);
        load(1, 32'h0000_0003);
        load(2, 32'h0000_0000);
        do_arm();
        strobe(32'hFFFF_FFF3); expect_out("masked_hit", 1'b1, 1'b0);

        // Level qualification
        load(2, 32'h0002_0000);
        do_arm();
        lvl_i = 1;
        strobe(32'h0000_0003); expect_out("lvl_low", 1'b0, 1'b0);
        lvl_i = 2;
        strobe(32'h0000_0003); expect_out("lvl_ok", 1'b1, 1'b0);
        lvl_i = 0;

        // Delay of 3 strobes with idle cycles interleaved
        load(2, 32'h0000_0003);
        do_arm();
        strobe(32'h0000_0003); expect_out("dly_hit", 1'b0, 1'b0);
        tick(); tick();
        strobe(32'h1234_5678); expect_out("dly_1", 1'b0, 1'b0);
        tick();
        strobe(32'h0000_0000); expect_out("dly_2", 1'b0, 1'b0);
        tick(); tick(); tick();
        strobe(32'hDEAD_BEEF); expect_out("dly_3", 1'b1, 1'b0);

        // Serial mode on channel 5, pattern 1010
        load(0, 32'h0000_000F);
        load(1, 32'h0000_000A);
        load(2, 32'h0450_0000);
        do_arm();
        s = $urandom; s[5] = 1; strobe(s); expect_out("ser_1", 1'b0, 1'b0);
        s = $urandom; s[5] = 0; strobe(s); expect_out("ser_2", 1'b0, 1'b0);
        s = $urandom; s[5] = 1; strobe(s); expect_out("ser_3", 1'b0, 1'b0);
        s = $urandom; s[5] = 0; strobe(s); expect_out("ser_4", 1'b1, 1'b0);

        // Reset mid-delay
        load(0, 32'h0000_000F);
        load(1, 32'h0000_0003);
        load(2, 32'h0800_0005);
        do_arm();
        strobe(32'h0000_0003);
        strobe(32'h0000_0003);
        rst_in = 1; tick(); rst_in = 0;
        expect_out("rst_mid", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            strobe($urandom);
            expect_out("post_rst_idle", 1'b0, 1'b0);
        end
        do_arm();
        strobe($urandom); expect_out("post_rst_mask0", 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            rst_in     = (r == 0);
            set_mask_i = (r >= 1 && r <= 3);
            set_val_i  = (r >= 4 && r <= 6) || (r == 7);
            set_cfg_i  = (r >= 7 && r <= 9);
            arm_i      = ($urandom_range(0, 99) < 8);
            stb_i      = ($urandom_range(0, 99) < 60);
            lvl_i      = 2'($urandom_range(0, 3));
            if (set_cfg_i) begin
                cmd_i = $urandom & 32'hF00C_0000;
                cmd_i[15:0]  = 16'($urandom_range(0, 4));
                cmd_i[17:16] = 2'($urandom_range(0, 3));
                cmd_i[24:20] = 5'($urandom_range(0, 31));
                cmd_i[26]    = ($urandom_range(0, 3) == 0);
                cmd_i[27]    = $urandom_range(0, 1);
            end else if (set_mask_i) begin
                cmd_i = $urandom & $urandom & $urandom;
            end else begin
                cmd_i = $urandom;
            end
            if ($urandom_range(0, 1) == 1) smpls_i = m_val ^ ($urandom & ~m_mask);
            else smpls_i = $urandom;
            tick();
        end
        rst_in = 0; set_mask_i = 0; set_val_i = 0; set_cfg_i = 0;
        arm_i = 0; stb_i = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
